// File: rtl/sha256_msg_packer.sv
// sha256_msg_packer: packs a 32-bit word stream into 512-bit big-endian SHA-256
// message blocks and emits the matching bit-length configuration word.
// Optional feature macro: SHA256_PACKER_BSWAP_EN (byte-reverse each input word).
module sha256_msg_packer #(
    parameter logic [1:0]  CFG_SCHEME = 2'b00,
    parameter int unsigned SIZE_W     = 64
) (
    input  logic              clk,
    input  logic              sync_rst,
    input  logic [31:0]       in_data,
    input  logic [1:0]        in_bytes,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [511:0]      data_out,
    output logic              data_out_last,
    output logic              data_out_valid,
    input  logic              data_out_ready,
    output logic [SIZE_W-1:0] cfg_size,
    output logic [1:0]        cfg_scheme,
    output logic              cfg_last,
    output logic              cfg_valid,
    input  logic              cfg_ready
);

    localparam int unsigned WORDS = 16;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        SEND      = 2'd1,
        SEND_LAST = 2'd2
    } state_t;

    state_t             state;
    logic [3:0]         idx;
    logic [511:0]       blk;
    logic [SIZE_W-1:0]  cnt;

    logic [31:0]        word_sw;
    logic [31:0]        word_m;
    logic [SIZE_W-1:0]  inc;
    logic [511:0]       blk_wr;
    logic               last_done;

    // Byte ordering, tail-byte masking, length increment and slot write of the incoming word.
    always_comb begin
        word_sw = in_data;
        word_m  = 32'h0;
        inc     = SIZE_W'(32);
        blk_wr  = blk;
`ifdef SHA256_PACKER_BSWAP_EN
        word_sw = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};
`endif
        word_m = word_sw;
        if (in_last) begin
            case (in_bytes)
                2'd1:    begin word_m = word_sw & 32'hFF00_0000; inc = SIZE_W'(8);  end
                2'd2:    begin word_m = word_sw & 32'hFFFF_0000; inc = SIZE_W'(16); end
                2'd3:    begin word_m = word_sw & 32'hFFFF_FF00; inc = SIZE_W'(24); end
                default: begin word_m = word_sw;                 inc = SIZE_W'(32); end
            endcase
        end
        for (int i = 0; i < WORDS; i++) begin
            if (idx == 4'(i)) blk_wr[511-32*i -: 32] = word_m;
        end
    end

    // Final block and cfg word each complete independently; both must be gone to leave SEND_LAST.
    assign last_done = (!data_out_valid || data_out_ready) && (!cfg_valid || cfg_ready);

    // Packer FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state          <= FILL;
            idx            <= 4'd0;
            blk            <= '0;
            cnt            <= '0;
            in_ready       <= 1'b1;
            data_out_valid <= 1'b0;
            data_out_last  <= 1'b0;
            cfg_valid      <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid && in_ready) begin
                        blk <= blk_wr;
                        cnt <= cnt + inc;
                        if (in_last) begin
                            state          <= SEND_LAST;
                            idx            <= 4'd0;
                            in_ready       <= 1'b0;
                            data_out_valid <= 1'b1;
                            data_out_last  <= 1'b1;
                            cfg_valid      <= 1'b1;
                        end else if (idx == 4'd15) begin
                            state          <= SEND;
                            idx            <= 4'd0;
                            in_ready       <= 1'b0;
                            data_out_valid <= 1'b1;
                            data_out_last  <= 1'b0;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                SEND: begin
                    if (data_out_ready) begin
                        state          <= FILL;
                        blk            <= '0;
                        data_out_valid <= 1'b0;
                        in_ready       <= 1'b1;
                    end
                end
                SEND_LAST: begin
                    if (data_out_valid && data_out_ready) begin
                        data_out_valid <= 1'b0;
                        data_out_last  <= 1'b0;
                    end
                    if (cfg_valid && cfg_ready) cfg_valid <= 1'b0;
                    if (last_done) begin
                        state    <= FILL;
                        blk      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= FILL;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign data_out   = blk;
    assign cfg_size   = cnt;
    assign cfg_scheme = CFG_SCHEME;
    assign cfg_last   = cfg_valid;

endmodule

// File: tb/tb_sha256_msg_packer.sv
// Scoreboard bench for sha256_msg_packer: a word-level model pushes expected
// blocks/cfg words; a negedge monitor pops and compares on each transfer.
module tb_sha256_msg_packer;

    localparam logic [1:0] SCHEME = 2'b00;

    logic         clk = 1'b0;
    logic         sync_rst;
    logic [31:0]  in_data;
    logic [1:0]   in_bytes;
    logic         in_last;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] data_out;
    logic         data_out_last;
    logic         data_out_valid;
    logic         data_out_ready;
    logic [63:0]  cfg_size;
    logic [1:0]   cfg_scheme;
    logic         cfg_last;
    logic         cfg_valid;
    logic         cfg_ready;

    sha256_msg_packer #(.CFG_SCHEME(SCHEME), .SIZE_W(64)) dut (
        .clk(clk), .sync_rst(sync_rst),
        .in_data(in_data), .in_bytes(in_bytes), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_out(data_out), .data_out_last(data_out_last),
        .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
        .cfg_size(cfg_size), .cfg_scheme(cfg_scheme), .cfg_last(cfg_last),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [511:0] d;
        logic         last;
    } blk_t;

    blk_t        exp_q[$];
    logic [63:0] cfg_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_blocks = 0;

    logic [31:0] m_blk [16];
    int          m_idx = 0;
    logic [63:0] m_cnt = 64'd0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] m_pack();
        logic [511:0] r = '0;
        for (int k = 0; k < 16; k++) r[511-32*k -: 32] = m_blk[k];
        return r;
    endfunction

    task automatic m_clear();
        for (int k = 0; k < 16; k++) m_blk[k] = 32'h0;
        m_idx = 0;
        m_cnt = 64'd0;
    endtask

    // Update the model, then drive one word and wait (bounded) for its transfer.
    task automatic send_word(input logic [31:0] d, input logic [1:0] b, input logic l);
        logic [31:0] w;
        int keep;
        bit  ok;
        w = d;
`ifdef SHA256_PACKER_BSWAP_EN
        w = {d[7:0], d[15:8], d[23:16], d[31:24]};
`endif
        keep = (!l || b == 2'd0) ? 4 : int'(b);
        w = w & ~(32'hFFFF_FFFF >> (8 * keep));
        m_blk[m_idx] = w;
        m_cnt = m_cnt + 64'(8 * keep);
        if (l || m_idx == 15) begin
            exp_q.push_back('{d: m_pack(), last: l});
            if (l) begin
                cfg_q.push_back(m_cnt);
                m_clear();
            end else begin
                for (int k = 0; k < 16; k++) m_blk[k] = 32'h0;
                m_idx = 0;
            end
        end else begin
            m_idx++;
        end

        in_data  = d;
        in_bytes = b;
        in_last  = l;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) check("in_ready_timeout", {511'h0, in_ready}, 512'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        sync_rst = 1'b1;
        @(posedge clk);
        #1;
        sync_rst = 1'b0;
        m_clear();
    endtask

    // Scoreboard: compare every block and cfg transfer against the queued expectation.
    always @(negedge clk) begin
        if (sync_rst === 1'b0 && data_out_valid === 1'b1 && data_out_ready === 1'b1) begin
            n_blocks++;
            if (exp_q.size() == 0) begin
                check("extra_block", {511'h0, data_out_valid}, 512'h0);
            end else begin
                blk_t e;
                e = exp_q.pop_front();
                check("blk_data", data_out, e.d);
                check("blk_last", {511'h0, data_out_last}, {511'h0, e.last});
            end
        end
        if (sync_rst === 1'b0 && cfg_valid === 1'b1 && cfg_ready === 1'b1) begin
            if (cfg_q.size() == 0) begin
                check("extra_cfg", {511'h0, cfg_valid}, 512'h0);
            end else begin
                logic [63:0] c;
                c = cfg_q.pop_front();
                check("cfg_size", {448'h0, cfg_size}, {448'h0, c});
                check("cfg_last", {511'h0, cfg_last}, 512'h1);
                check("cfg_scheme", {510'h0, cfg_scheme}, {510'h0, SCHEME});
            end
        end
    end

    initial begin
        logic [511:0] held;
        logic [63:0]  held_size;
        sync_rst = 1'b0; in_data = '0; in_bytes = '0; in_last = 1'b0; in_valid = 1'b0;
        data_out_ready = 1'b1; cfg_ready = 1'b1;
        m_clear();
        #2;
        do_reset();

        // Reset state
        check("rst_in_ready", {511'h0, in_ready}, 512'h1);
        check("rst_dvalid", {511'h0, data_out_valid}, 512'h0);
        check("rst_cvalid", {511'h0, cfg_valid}, 512'h0);
        check("rst_data", data_out, 512'h0);
        check("rst_size", {448'h0, cfg_size}, 512'h0);

`ifdef SHA256_PACKER_BSWAP_EN
        // Little-endian "abc" lands big-endian
        send_word(32'h0063_6261, 2'd3, 1'b1);
        check("bswap_word0", {480'h0, data_out[511:480]}, {480'h0, 32'h6162_6300});
        check("bswap_size", {448'h0, cfg_size}, 512'd24);
`else
        // "abc": block and cfg valid the cycle after the last word
        send_word(32'h6162_6300, 2'd3, 1'b1);
        check("abc_dvalid_lat", {511'h0, data_out_valid}, 512'h1);
        check("abc_cvalid_lat", {511'h0, cfg_valid}, 512'h1);
        check("abc_in_ready", {511'h0, in_ready}, 512'h0);
`endif

        // One-byte message, with garbage in the unused bytes
        send_word(32'hA5FF_EE11, 2'd1, 1'b1);

        // 16 words with last in slot 15: one full final block
        for (int k = 0; k < 16; k++) send_word(32'(k), 2'd0, k == 15);

        // 17 words: full non-last block then a 2-byte tail block, 528 bits
        for (int k = 0; k < 16; k++) send_word(32'h100 + 32'(k), 2'd0, 1'b0);
        send_word(32'h1122_3344, 2'd2, 1'b1);

        // Backpressure on data, cfg ready
        repeat (3) @(posedge clk);
        #1;
        data_out_ready = 1'b0;
        send_word(32'hDEAD_BEEF, 2'd0, 1'b1);
        held = data_out;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_d_stable", data_out, held);
            check("bp_d_in_ready", {511'h0, in_ready}, 512'h0);
            check("bp_d_valid", {511'h0, data_out_valid}, 512'h1);
            if (i > 0) check("bp_d_cfg_done", {511'h0, cfg_valid}, 512'h0);
        end
        @(posedge clk);
        #1;
        data_out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_d_back_fill", {511'h0, in_ready}, 512'h1);
        check("bp_d_dvalid_off", {511'h0, data_out_valid}, 512'h0);

        // Backpressure on cfg, data ready
        cfg_ready = 1'b0;
        send_word(32'h0102_0304, 2'd3, 1'b1);
        held_size = cfg_size;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_c_stable", {448'h0, cfg_size}, {448'h0, held_size});
            check("bp_c_in_ready", {511'h0, in_ready}, 512'h0);
            check("bp_c_valid", {511'h0, cfg_valid}, 512'h1);
            if (i > 0) check("bp_c_data_done", {511'h0, data_out_valid}, 512'h0);
        end
        @(posedge clk);
        #1;
        cfg_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_c_back_fill", {511'h0, in_ready}, 512'h1);
        check("bp_c_cvalid_off", {511'h0, cfg_valid}, 512'h0);

        // Reset mid-message discards the partial block and count
        for (int k = 0; k < 7; k++) send_word(32'hCAFE_0000 + 32'(k), 2'd0, 1'b0);
        do_reset();
        check("mrst_in_ready", {511'h0, in_ready}, 512'h1);
        check("mrst_dvalid", {511'h0, data_out_valid}, 512'h0);
        check("mrst_cvalid", {511'h0, cfg_valid}, 512'h0);
        check("mrst_data", data_out, 512'h0);
        send_word(32'h7788_99AA, 2'd0, 1'b1);

        repeat (5) @(posedge clk);
        #1;
        check("blocks_seen", 512'(n_blocks), 512'd8);
        check("exp_q_drained", 512'(exp_q.size()), 512'd0);
        check("cfg_q_drained", 512'(cfg_q.size()), 512'd0);
        check("idle_dvalid", {511'h0, data_out_valid}, 512'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
